// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter. On an accepted start it captures
// a PAT_W-bit pattern and shifts it out MSB first, one bit per clk, repeating
// the frame repeat_cnt times with gap idle cycles between frames.
// Optional feature macro: SEQ_TX_PARITY_EN appends an odd-parity bit to each
// frame (FLEN = PAT_W + 1). Without it FLEN = PAT_W and no parity logic exists.
// Ports:
//   clk        : rising-edge clock
//   reset      : synchronous active-low reset
//   start      : transfer request, sampled only in IDLE
//   pattern    : frame bits, MSB first, captured on accepted start
//   repeat_cnt : number of frames, captured on accepted start
//   gap        : idle cycles between frames, captured on accepted start
//   d_out      : registered serial data
//   d_valid    : 1 while d_out carries a frame bit
//   busy       : 1 from the cycle after accepted start through DONE
//   done       : one-cycle pulse after the last bit of the last frame
module seq_pattern_tx #(
    parameter int PAT_W = 4,
    parameter int RPT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [RPT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap,
    output logic             d_out,
    output logic             d_valid,
    output logic             busy,
    output logic             done
);

`ifdef SEQ_TX_PARITY_EN
    localparam int FLEN = PAT_W + 1;
`else
    localparam int FLEN = PAT_W;
`endif
    localparam int CW = $clog2(FLEN);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [FLEN-1:0]   frame_q, frame_d;
    logic [FLEN-1:0]   sh_q, sh_d;
    logic [FLEN-1:0]   frame_in;
    logic [CW-1:0]     bit_q, bit_d;
    logic [RPT_W-1:0]  frm_q, frm_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [GAP_W-1:0]  gcnt_q, gcnt_d;
    logic              d_out_q, d_out_d;
    logic              d_valid_q, d_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Frame image as transmitted: pattern, optionally followed by odd parity.
    always_comb begin
`ifdef SEQ_TX_PARITY_EN
        frame_in = {pattern, ~^pattern};
`else
        frame_in = pattern;
`endif
    end

    // Outputs are computed for the next state so that they come out registered.
    // bit_q holds the number of frame bits still to send after the current one;
    // frm_q holds the number of frames still to send after the current one.
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        sh_d      = sh_q;
        bit_d     = bit_q;
        frm_d     = frm_q;
        gap_d     = gap_q;
        gcnt_d    = gcnt_q;
        d_out_d   = 1'b0;
        d_valid_d = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    frame_d = frame_in;
                    gap_d   = gap;
                    busy_d  = 1'b1;
                    if (repeat_cnt != '0) begin
                        state_d   = SHIFT;
                        frm_d     = repeat_cnt - RPT_W'(1);
                        d_out_d   = frame_in[FLEN-1];
                        d_valid_d = 1'b1;
                        sh_d      = frame_in << 1;
                        bit_d     = CW'(FLEN - 1);
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        frm_d   = '0;
                    end
                end
            end

            SHIFT: begin
                if (bit_q != '0) begin
                    d_out_d   = sh_q[FLEN-1];
                    d_valid_d = 1'b1;
                    sh_d      = sh_q << 1;
                    bit_d     = bit_q - CW'(1);
                end else if (frm_q != '0) begin
                    frm_d = frm_q - RPT_W'(1);
                    if (gap_q != '0) begin
                        state_d = GAP;
                        gcnt_d  = gap_q - GAP_W'(1);
                    end else begin
                        // Back-to-back reload: next frame MSB with no bubble.
                        d_out_d   = frame_q[FLEN-1];
                        d_valid_d = 1'b1;
                        sh_d      = frame_q << 1;
                        bit_d     = CW'(FLEN - 1);
                    end
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end

            GAP: begin
                // gcnt_q starts at gap-1, so GAP lasts exactly gap cycles.
                if (gcnt_q == '0) begin
                    state_d   = SHIFT;
                    d_out_d   = frame_q[FLEN-1];
                    d_valid_d = 1'b1;
                    sh_d      = frame_q << 1;
                    bit_d     = CW'(FLEN - 1);
                end else begin
                    gcnt_d = gcnt_q - GAP_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            sh_q      <= '0;
            bit_q     <= '0;
            frm_q     <= '0;
            gap_q     <= '0;
            gcnt_q    <= '0;
            d_out_q   <= 1'b0;
            d_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            sh_q      <= sh_d;
            bit_q     <= bit_d;
            frm_q     <= frm_d;
            gap_q     <= gap_d;
            gcnt_q    <= gcnt_d;
            d_out_q   <= d_out_d;
            d_valid_q <= d_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign d_out   = d_out_q;
    assign d_valid = d_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: self-checking bench for seq_pattern_tx.
// Table vectors, hand-written corner sequences and randomized transfers.
module tb_seq_pattern_tx;

    localparam int PAT_W = 4;
    localparam int RPT_W = 8;
    localparam int GAP_W = 4;
`ifdef SEQ_TX_PARITY_EN
    localparam int FLEN = PAT_W + 1;
`else
    localparam int FLEN = PAT_W;
`endif

    logic             clk;
    logic             reset;
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [RPT_W-1:0] repeat_cnt;
    logic [GAP_W-1:0] gap;
    logic             d_out;
    logic             d_valid;
    logic             busy;
    logic             done;

    int tests;
    int fails;

    seq_pattern_tx #(
        .PAT_W(PAT_W),
        .RPT_W(RPT_W),
        .GAP_W(GAP_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pattern   (pattern),
        .repeat_cnt(repeat_cnt),
        .gap       (gap),
        .d_out     (d_out),
        .d_valid   (d_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-cycle expectation: valid, data, busy, done.
    typedef struct packed {
        logic v;
        logic d;
        logic b;
        logic dn;
    } ob_t;

    typedef struct {
        logic [PAT_W-1:0] pat;
        int               rpt;
        int               gp;
        int               exp_done;
        int               exp_nv;
    } vec_t;

    ob_t  exp_q[$];
    vec_t tbl[7];

    function automatic void chk(string nm, int k, logic [31:0] act,
                                logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, k, act, exp);
        end
    endfunction

    // Reference stream: frames of pattern bits (plus parity), gap idles
    // between frames, one done cycle, then one idle cycle.
    function automatic void build(logic [PAT_W-1:0] p, int r, int g);
        exp_q.delete();
        if (r == 0) begin
            exp_q.push_back(4'b0011);
        end else begin
            for (int f = 0; f < r; f++) begin
                for (int i = PAT_W - 1; i >= 0; i--)
                    exp_q.push_back({1'b1, p[i], 1'b1, 1'b0});
`ifdef SEQ_TX_PARITY_EN
                exp_q.push_back({1'b1, ~^p, 1'b1, 1'b0});
`endif
                if (f < r - 1)
                    for (int j = 0; j < g; j++)
                        exp_q.push_back(4'b0010);
            end
            exp_q.push_back(4'b0011);
        end
        exp_q.push_back(4'b0000);
    endfunction

    function automatic int done_cycle(int r, int g);
        if (r == 0) return 1;
        return r * FLEN + (r - 1) * g + 1;
    endfunction

    task automatic run_xfer(input logic [PAT_W-1:0] p, input int r,
                            input int g, input bit noise,
                            output int done_at, output int nv);
        ob_t e;
        int  n;
        @(negedge clk);
        pattern    = p;
        repeat_cnt = RPT_W'(r);
        gap        = GAP_W'(g);
        start      = 1'b1;
        build(p, r, g);
        n       = exp_q.size();
        done_at = -1;
        nv      = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            e = exp_q[k-1];
            chk("stream", k, 32'({d_valid, d_out, busy, done}), 32'(e));
            if (done && done_at < 0) done_at = k;
            if (d_valid) nv++;
            if (noise && k < n - 1) begin
                start      = 1'($urandom);
                pattern    = PAT_W'($urandom);
                repeat_cnt = RPT_W'($urandom);
                gap        = GAP_W'($urandom);
                if (k == 1) begin
                    start   = 1'b1;
                    pattern = 4'b0110;
                end
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk(nm, 0, 32'(seen), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int               da;
        int               nv;
        logic [PAT_W-1:0] rp;
        int               rr;
        int               rg;
        bit               rn;
        logic [7:0]       got;
        logic [7:0]       want;

        tests = 0;
        fails = 0;

`ifdef SEQ_TX_PARITY_EN
        tbl[0] = '{4'b1010, 1, 0, 6, 5};
        tbl[1] = '{4'b1010, 3, 0, 16, 15};
        tbl[2] = '{4'b1100, 2, 2, 13, 10};
        tbl[3] = '{4'b0101, 0, 3, 1, 0};
        tbl[4] = '{4'b0110, 2, 15, 26, 10};
        tbl[5] = '{4'b1111, 255, 0, 1276, 1275};
        tbl[6] = '{4'b0001, 4, 1, 24, 20};
`else
        tbl[0] = '{4'b1010, 1, 0, 5, 4};
        tbl[1] = '{4'b1010, 3, 0, 13, 12};
        tbl[2] = '{4'b1100, 2, 2, 11, 8};
        tbl[3] = '{4'b0101, 0, 3, 1, 0};
        tbl[4] = '{4'b0110, 2, 15, 24, 8};
        tbl[5] = '{4'b1111, 255, 0, 1021, 1020};
        tbl[6] = '{4'b0001, 4, 1, 20, 16};
`endif

        reset      = 1'b0;
        start      = 1'b0;
        pattern    = '0;
        repeat_cnt = '0;
        gap        = '0;
        repeat (2) @(negedge clk);
        chk("reset_outs", 0, 32'({d_valid, d_out, busy, done}), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_xfer(tbl[i].pat, tbl[i].rpt, tbl[i].gp, 1'b0, da, nv);
            chk("tbl_done_cyc", i, 32'(da), 32'(tbl[i].exp_done));
            chk("tbl_nvalid", i, 32'(nv), 32'(tbl[i].exp_nv));
        end

        // start pulsed with 0110 during frame 1 must be ignored.
        run_xfer(4'b1010, 2, 0, 1'b1, da, nv);
        chk("ignore_start_done", 0, 32'(da), 32'(2 * FLEN + 1));

        // start held high: re-accepted in the first IDLE cycle after DONE.
        @(negedge clk);
        pattern    = 4'b1010;
        repeat_cnt = 8'd1;
        gap        = 4'd0;
        start      = 1'b1;
        for (int k = 1; k <= FLEN + 2; k++) begin
            @(negedge clk);
            if (k == FLEN + 1)
                chk("hold_done", k, 32'({busy, done}), 32'b11);
            if (k == FLEN + 2)
                chk("hold_idle", k, 32'({d_valid, busy, done}), 32'b000);
        end
        @(negedge clk);
        chk("hold_restart", 0, 32'({d_valid, d_out, busy}), 32'b111);
        start = 1'b0;
        wait_done("hold_finish");

        // Reset at the third bit of a frame: no partial completion.
        @(negedge clk);
        pattern    = 4'b1010;
        repeat_cnt = 8'd2;
        gap        = 4'd0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("bit3_before_rst", 3, 32'({d_valid, d_out}), 32'b11);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_reset", 4, 32'({d_valid, d_out, busy, done}), 32'd0);
        reset = 1'b1;
        run_xfer(4'b1010, 1, 0, 1'b0, da, nv);
        chk("post_reset_done", 0, 32'(da), 32'(FLEN + 1));

        // Explicit bit image of 1110, including parity when enabled.
`ifdef SEQ_TX_PARITY_EN
        want = 8'b0001_1100;
`else
        want = 8'b0000_1110;
`endif
        @(negedge clk);
        pattern    = 4'b1110;
        repeat_cnt = 8'd1;
        gap        = 4'd0;
        start      = 1'b1;
        got        = '0;
        for (int k = 1; k <= FLEN; k++) begin
            @(negedge clk);
            start = 1'b0;
            got   = {got[6:0], d_out & d_valid};
        end
        chk("frame_1110", 0, 32'(got), 32'(want));
        wait_done("frame_1110_done");

        for (int t = 0; t < 20; t++) begin
            rp = PAT_W'($urandom);
            rr = int'($urandom_range(0, 5));
            rg = int'($urandom_range(0, 3));
            rn = 1'($urandom_range(0, 1));
            run_xfer(rp, rr, rg, rn, da, nv);
            chk("rand_done_cyc", t, 32'(da), 32'(done_cycle(rr, rg)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
